popcount_accum: RTL and testbench

POPCOUNT_ACCUM -- requirements
Module: popcount_accum

---
 rtl/popcount_pkg.sv | 28 ++
 rtl/popcount_word.sv | 25 ++
 rtl/popcount_accum.sv | 140 ++++++++++++++
 tb/tb_popcount_accum.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared state encoding and width helper for the popcount accumulator
//
// Purpose: holds the three-state FSM encoding and the ceil(log2) function
// used to size the sum, word-count and per-word popcount buses.
// Ports: none (package).

package popcount_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest w such that 2**w >= value; callers pass (max_count + 1) so the
  // result is the number of bits needed to hold 0..max_count.
  function automatic int clog2w(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/popcount_word.sv
// rtl/popcount_word.sv - combinational popcount of one input word
//
// Purpose: counts the set bits of a single DATA_W-bit word.
// Ports:
//   word_i   in   DATA_W  word to count
//   count_o  out  CNT_W   number of ones in word_i (0..DATA_W)

module popcount_word
  import popcount_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int CNT_W  = clog2w(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] word_i,
  output logic [CNT_W-1:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count_o = count_o + CNT_W'(word_i[i]);
    end
  end

endmodule

// File: rtl/popcount_accum.sv
// rtl/popcount_accum.sv - per-message accumulator of one/zero bit counts
//
// Purpose: after start, accepts up to MAX_WORDS beats, summing the ones
// (or zeros, when count_zeros was set with start) of every accepted beat.
// The message ends on in_last or is truncated at MAX_WORDS (err_len=1);
// the result is then offered on out_valid until out_ready.
// Ports:
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous active-low reset
//   start        in   1       begin a message (honoured only in IDLE)
//   count_zeros  in   1       1 = count zeros, 0 = count ones (taken with start)
//   in_data      in   DATA_W  message beat
//   in_valid     in   1       in_data valid
//   in_last      in   1       final beat of the message
//   in_ready     out  1       beat accepted this cycle when in_valid
//   busy         out  1       FSM not in IDLE
//   out_valid    out  1       result available (DONE)
//   out_ready    in   1       consumer takes the result
//   sum          out  SUM_W   count of selected bits over the message
//   words        out  WCNT_W  beats accepted in the message
//   err_len      out  1       message truncated at MAX_WORDS without in_last

module popcount_accum
  import popcount_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int MAX_WORDS = 1024,
  localparam int SUM_W     = clog2w(DATA_W * MAX_WORDS + 1),
  localparam int WCNT_W    = clog2w(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              count_zeros,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum,
  output logic [WCNT_W-1:0] words,
  output logic              err_len
);

  localparam int PC_W = clog2w(DATA_W + 1);

  state_t              state_q;
  logic                in_ready_q;
  logic                busy_q;
  logic                out_valid_q;
  logic [SUM_W-1:0]    sum_q;
  logic [WCNT_W-1:0]   words_q;
  logic                err_len_q;
  logic                zero_mode_q;

  logic [PC_W-1:0]     pc_ones;
  logic [PC_W-1:0]     pc_sel;
  logic [SUM_W-1:0]    sum_d;
  logic [WCNT_W-1:0]   words_d;
  logic                accept;
  logic                hit_max;

  popcount_word #(
    .DATA_W (DATA_W)
  ) u_popcount_word (
    .word_i  (in_data),
    .count_o (pc_ones)
  );

  // Zero count is the complement of the one count within the word width.
  assign pc_sel  = zero_mode_q ? (PC_W'(DATA_W) - pc_ones) : pc_ones;
  assign sum_d   = sum_q + SUM_W'(pc_sel);
  assign words_d = words_q + WCNT_W'(1);
  assign accept  = in_valid && in_ready_q;
  assign hit_max = (words_d == WCNT_W'(MAX_WORDS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      words_q     <= '0;
      err_len_q   <= 1'b0;
      zero_mode_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            sum_q       <= '0;
            words_q     <= '0;
            err_len_q   <= 1'b0;
            zero_mode_q <= count_zeros;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_q   <= sum_d;
            words_q <= words_d;
            // in_last wins over truncation: a last beat landing exactly on
            // MAX_WORDS is a complete message, not a length error.
            if (in_last || hit_max) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              err_len_q   <= !in_last;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign words     = words_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_popcount_accum.sv
// tb/tb_popcount_accum.sv - scoreboard bench for popcount_accum (DATA_W=8, MAX_WORDS=4)

module tb_popcount_accum;

  localparam int DATA_W    = 8;
  localparam int MAX_WORDS = 4;
  localparam int SUM_W     = 6;
  localparam int WCNT_W    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              count_zeros;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  sum;
  logic [WCNT_W-1:0] words;
  logic              err_len;

  typedef struct packed {
    logic [SUM_W-1:0]  sum;
    logic [WCNT_W-1:0] words;
    logic              err;
  } res_t;

  res_t       sb_q[$];
  logic [7:0] msg[$];
  int         checks = 0;
  int         errors = 0;

  popcount_accum #(
    .DATA_W    (DATA_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count_zeros (count_zeros),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .words       (words),
    .err_len     (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the offered beats, accepting each until the one flagged
  // last or until MAX_WORDS beats have been taken.
  task automatic model(input logic zm, input logic with_last, output res_t e, output int nacc);
    int total;
    total = 0;
    nacc  = 0;
    e     = '0;
    for (int i = 0; i < msg.size(); i++) begin
      nacc++;
      total += zm ? (DATA_W - $countones(msg[i])) : $countones(msg[i]);
      if (with_last && i == msg.size() - 1) break;
      if (nacc == MAX_WORDS) begin
        e.err = 1'b1;
        break;
      end
    end
    e.sum   = SUM_W'(total);
    e.words = WCNT_W'(nacc);
  endtask

  task automatic run_msg(input logic zm, input logic with_last, input int gapmax,
                         input int hold, input bit pulse_start);
    res_t e;
    int   nacc;
    int   g;
    model(zm, with_last, e, nacc);
    start = 1'b1;
    count_zeros = zm;
    tick();
    start = 1'b0;
    count_zeros = 1'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    chk("in_ready_accum", 32'(in_ready), 1);
    sb_q.push_back(e);
    for (int i = 0; i < nacc; i++) begin
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        tick();
        chk("gap_out_valid", 32'(out_valid), 0);
        chk("gap_in_ready", 32'(in_ready), 1);
      end
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = with_last && (i == msg.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("out_valid_latency", 32'(out_valid), 1);
    chk("in_ready_done", 32'(in_ready), 0);
    if (nacc < msg.size()) begin
      in_valid = 1'b1;
      in_data  = msg[nacc];
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("no_accept_in_done", 32'(in_ready), 0);
    end
    repeat (hold) begin
      start = pulse_start;
      tick();
      start = 1'b0;
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_busy", 32'(busy), 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_sum", 32'(sum), 32'(e.sum));
    chk("idle_words", 32'(words), 32'(e.words));
    chk("idle_err_len", 32'(err_len), 32'(e.err));
  endtask

  // Monitor: every cycle the result is offered it must match the oldest
  // expectation; the expectation retires on the handshake.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum %0d expected no result", sum);
      end else begin
        chk("result_sum", 32'(sum), 32'(sb_q[0].sum));
        chk("result_words", 32'(words), 32'(sb_q[0].words));
        chk("result_err_len", 32'(err_len), 32'(sb_q[0].err));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit wl;
    int n;
    reset = 1'b0;
    start = 1'b0;
    count_zeros = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_words", 32'(words), 0);
    chk("rst_err_len", 32'(err_len), 0);
    reset = 1'b1;
    tick();

    msg = {8'hFF, 8'h0F, 8'h01};
    run_msg(1'b0, 1'b1, 0, 5, 1'b1);
    msg = {8'h00};
    run_msg(1'b1, 1'b1, 0, 0, 1'b0);
    msg = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_msg(1'b0, 1'b0, 0, 2, 1'b0);
    msg = {8'h03, 8'h05};
    run_msg(1'b0, 1'b1, 3, 1, 1'b0);

    // Reset in the middle of a message, with stimulus that must be ignored.
    start = 1'b1;
    count_zeros = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_last = 1'b0;
    tick();
    reset = 1'b0;
    start = 1'b1;
    in_last = 1'b1;
    tick();
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_sum", 32'(sum), 0);
    chk("midrst_words", 32'(words), 0);
    msg = {8'h01};
    run_msg(1'b0, 1'b1, 0, 0, 1'b0);

    for (int m = 0; m < 40; m++) begin
      wl = ($urandom_range(9, 0) < 7);
      n  = wl ? int'($urandom_range(6, 1)) : int'($urandom_range(6, 4));
      msg = {};
      for (int b = 0; b < n; b++) msg.push_back(8'($urandom));
      run_msg(1'($urandom), wl, 2, int'($urandom_range(3, 0)), 1'($urandom));
    end

    tick();
    tick();
    chk("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
